fifo_wr_arbiter: RTL
====================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each requester's data word and of wdata.
REQ-002 Parameter NUM_REQ, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter MAX_BURST, default 4, maximum beats per grant; legal range 1..16.
REQ-004 The block uses one clock; reset is asynchronous and active-low.
REQ-005 wr_clk  input  1  write-domain clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  NUM_REQ  per-requester data-valid flags.
REQ-008 req_last  input  NUM_REQ  per-requester end-of-burst marker, qualified by req_valid.
REQ-009 req_data  input  NUM_REQ*DATA_WIDTH  packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 req_ready  output  NUM_REQ  per-requester accept flags.
REQ-011 full  input  1  write-side full flag from the asynchronous FIFO.
REQ-012 wr  output  1  FIFO write strobe.
REQ-013 wdata  output  DATA_WIDTH  FIFO write data.
REQ-014 grant_active  output  1  high while a burst is owned.
REQ-015 grant_id  output  3  index of the current or most recent owner.
REQ-016 stall_cnt  output  16  saturating count of cycles where the owner had valid data but full was high.

Function
REQ-017 The FSM SHALL have two states: IDLE and BURST.
REQ-018 In IDLE with any req_valid high, the block SHALL pick the first valid requester at or after rr_ptr (modulo NUM_REQ), register it as owner, load grant_id, clear beat_cnt and enter BURST next cycle; no transfer occurs in IDLE (1-cycle arbitration latency).
REQ-019 In IDLE with no req_valid, the block SHALL remain in IDLE.
REQ-020 req_ready[i] SHALL equal (state==BURST && owner==i && !full), combinationally; all other req_ready bits SHALL be 0.
REQ-021 A transfer SHALL occur when req_valid[owner] && req_ready[owner]; in that cycle wr=1 and wdata=req_data of owner, combinationally (zero latency).
REQ-022 wr SHALL be 0 and wdata SHALL be 0 whenever no transfer occurs; wr SHALL never be 1 while full is 1.
REQ-023 Each transfer SHALL increment beat_cnt (width clog2(MAX_BURST)+1).
REQ-024 BURST SHALL exit to IDLE after a transfer with req_last[owner]=1, or after the transfer that makes beat_cnt equal MAX_BURST.
REQ-025 BURST SHALL exit to IDLE when req_valid[owner]=0 (owner released grant), without a transfer.
REQ-026 When full=1 and req_valid[owner]=1, the block SHALL stay in BURST, perform no transfer, and increment stall_cnt, saturating at 16'hFFFF.
REQ-027 On every BURST exit, rr_ptr SHALL load (owner+1) modulo NUM_REQ, wrapping NUM_REQ-1 to 0.
REQ-028 grant_active SHALL be 1 exactly while state==BURST; grant_id SHALL hold its value in IDLE.
REQ-029 Changes of non-owner req_valid during BURST SHALL have no effect until the next IDLE cycle.

Reset
REQ-030 While rst_n=0: state=IDLE, rr_ptr=0, owner=0, grant_id=0, beat_cnt=0, stall_cnt=0, grant_active=0, wr=0, wdata=0, req_ready=0.
REQ-031 Reset asserted mid-burst SHALL abandon the burst immediately with no further write; arbitration after release starts from requester 0.

Structure
REQ-032 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and default values of DATA_WIDTH, NUM_REQ, MAX_BURST.
REQ-033 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, rr_ptr; outputs: winner index, any_valid).

Verification
REQ-034 Reset, then req_valid=4'b0001, req_last on 3rd beat, data 8'h11,8'h22,8'h33 -> grant_id=0 one cycle later, three consecutive wr pulses with those data, IDLE, rr_ptr=1.
REQ-035 req_valid=4'b1111 held, req_last=0 -> grants in order 0,1,2,3,0, each exactly 4 beats, one idle arbitration cycle between bursts.
REQ-036 Owner 2 in BURST, full=1 for 5 cycles -> wr=0, req_ready=0, stall_cnt=5, burst resumes with beat_cnt unchanged when full drops.
REQ-037 Owner 3 mid-burst drops req_valid -> IDLE next cycle, no write, rr_ptr wraps to 0.
REQ-038 rst_n pulsed low during 2nd beat of a burst -> wr=0 immediately, all outputs at reset values, next grant goes to lowest-index valid requester.
REQ-039 Random valid/last/full for 10000 cycles -> wr never high with full high, every accepted word appears on wdata exactly once in per-requester order.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the round-robin burst arbiter that feeds
// the write side of an asynchronous FIFO.
package fifo_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_MAX_BURST  = 4;
    localparam int ID_W           = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Successor of a requester index, wrapping the last requester back to 0.
    function automatic logic [ID_W-1:0] next_index(input logic [ID_W-1:0] idx, input int num);
        return (int'(idx) == num - 1) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first asserted request at or after
// rr_ptr, searching upward and wrapping modulo NUM_REQ.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    winner,
    output logic               any_valid
);

    logic [7:0] req_pad;

    assign req_pad   = 8'(req);
    assign any_valid = |req;

    function automatic logic [ID_W-1:0] cand(input logic [ID_W-1:0] ptr, input int k);
        logic [ID_W:0] s;
        s = {1'b0, ptr} + (ID_W+1)'(k);
        if (s >= (ID_W+1)'(NUM_REQ)) begin
            s = s - (ID_W+1)'(NUM_REQ);
        end
        return s[ID_W-1:0];
    endfunction

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_pad[cand(rr_ptr, k)]) begin
                winner = cand(rr_ptr, k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-oriented round-robin arbiter merging NUM_REQ requesters onto the
// write port of an asynchronous FIFO; one idle arbitration cycle per grant.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          wr_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          full,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic                          grant_active,
    output logic [2:0]                    grant_id,
    output logic [15:0]                   stall_cnt
);

    localparam int BEAT_W = $clog2(MAX_BURST) + 1;

    arb_state_t            state;
    logic [ID_W-1:0]       owner;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       winner;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BEAT_W-1:0]     beat_next;
    logic                  any_valid;
    logic                  in_burst;
    logic                  owner_valid;
    logic                  owner_last;
    logic                  xfer;
    logic [7:0]            valid_pad;
    logic [7:0]            last_pad;
    logic [DATA_WIDTH-1:0] data_arr [8];

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        if (i < NUM_REQ) begin : g_live
            assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign data_arr[i] = '0;
        end
    end

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (winner),
        .any_valid (any_valid)
    );

    assign valid_pad   = 8'(req_valid);
    assign last_pad    = 8'(req_last);
    assign in_burst    = (state == BURST);
    assign owner_valid = valid_pad[owner];
    assign owner_last  = last_pad[owner];
    assign beat_next   = beat_cnt + BEAT_W'(1);

    // Handshake: a beat moves only in a cycle where req_valid[i] and
    // req_ready[i] are both high; ready depends on grant and full, never on
    // valid, and the requester must hold its data until that cycle.
    assign req_ready    = (in_burst && !full) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << owner) : '0;
    assign xfer         = in_burst && owner_valid && !full;
    assign wr           = xfer;
    assign wdata        = xfer ? data_arr[owner] : '0;
    assign grant_active = in_burst;
    assign grant_id     = owner;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner    <= winner;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_valid) begin
                        state  <= IDLE;
                        rr_ptr <= next_index(owner, NUM_REQ);
                    end else if (full) begin
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end else begin
                        beat_cnt <= beat_next;
                        if (owner_last || beat_next == BEAT_W'(MAX_BURST)) begin
                            state  <= IDLE;
                            rr_ptr <= next_index(owner, NUM_REQ);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
